// File: rtl/python_timing_encoder.sv
// Python-style sync-channel timing encoder: frames of LINE/BLANK words framed by FS/LS/LE/FE codes.
// Optional build macro PYTHON_ENC_TESTPAT_EN replaces pixel input with an internal ramp pattern.
module python_timing_encoder #(
    parameter int                          CHANNEL_NUM      = 4,
    parameter int                          SENSOR_DAT_WIDTH = 10,
    parameter logic [SENSOR_DAT_WIDTH-1:0] TR_CODE          = 10'h3A6,
    parameter logic [SENSOR_DAT_WIDTH-1:0] FS_CODE          = 10'h2AA,
    parameter logic [SENSOR_DAT_WIDTH-1:0] FE_CODE          = 10'h3AA,
    parameter logic [SENSOR_DAT_WIDTH-1:0] LS_CODE          = 10'h0AA,
    parameter logic [SENSOR_DAT_WIDTH-1:0] LE_CODE          = 10'h12A,
    parameter logic [SENSOR_DAT_WIDTH-1:0] BL_CODE          = 10'h015,
    parameter logic [SENSOR_DAT_WIDTH-1:0] IMG_CODE         = 10'h035
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    i_start,
    input  logic [15:0]                             iv_line_num,
    input  logic [15:0]                             iv_line_words,
    input  logic [15:0]                             iv_blank_words,
    input  logic [CHANNEL_NUM*SENSOR_DAT_WIDTH-1:0] iv_pix_data,
    output logic                                    o_pix_rd,
    output logic [CHANNEL_NUM*SENSOR_DAT_WIDTH-1:0] ov_data,
    output logic [SENSOR_DAT_WIDTH-1:0]             ov_ctrl,
    output logic                                    o_busy,
    output logic                                    o_frame_done
);

    localparam int DW = CHANNEL_NUM * SENSOR_DAT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LINE  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    // state_q and the counters describe the word currently on the outputs
    state_t                      state_q, state_d;
    logic [15:0]                 line_cnt_q, line_cnt_d;
    logic [15:0]                 word_cnt_q, word_cnt_d;
    logic [15:0]                 line_num_q, line_num_d;
    logic [15:0]                 line_words_q, line_words_d;
    logic [15:0]                 blank_words_q, blank_words_d;
    logic [SENSOR_DAT_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [DW-1:0]               data_q, data_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        pix_rd;
    logic                        last_line_q;
    logic                        last_line_d;

    assign last_line_q = (line_cnt_q == line_num_q - 16'd1);

    always_comb begin
        state_d       = state_q;
        line_cnt_d    = line_cnt_q;
        word_cnt_d    = word_cnt_q;
        line_num_d    = line_num_q;
        line_words_d  = line_words_q;
        blank_words_d = blank_words_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    line_num_d    = (iv_line_num == 16'd0) ? 16'd1 : iv_line_num;
                    line_words_d  = (iv_line_words < 16'd2) ? 16'd2 : iv_line_words;
                    blank_words_d = iv_blank_words;
                    line_cnt_d    = '0;
                    word_cnt_d    = '0;
                    state_d       = ST_LINE;
                end
            end
            ST_LINE: begin
                if (word_cnt_q == line_words_q - 16'd1) begin
                    word_cnt_d = '0;
                    if (blank_words_q != 16'd0) begin
                        state_d = ST_BLANK;
                    end else if (last_line_q) begin
                        state_d    = ST_IDLE;
                        line_cnt_d = '0;
                    end else begin
                        line_cnt_d = line_cnt_q + 16'd1;
                    end
                end else begin
                    word_cnt_d = word_cnt_q + 16'd1;
                end
            end
            ST_BLANK: begin
                if (word_cnt_q == blank_words_q - 16'd1) begin
                    word_cnt_d = '0;
                    if (last_line_q) begin
                        state_d    = ST_IDLE;
                        line_cnt_d = '0;
                    end else begin
                        state_d    = ST_LINE;
                        line_cnt_d = line_cnt_q + 16'd1;
                    end
                end else begin
                    word_cnt_d = word_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                line_cnt_d = '0;
                word_cnt_d = '0;
            end
        endcase
    end

    // Outputs are registered, so they are decoded from the next-state view of the frame
    assign last_line_d = (line_cnt_d == line_num_d - 16'd1);

    always_comb begin
        ctrl_d = TR_CODE;
        data_d = {CHANNEL_NUM{TR_CODE}};
        busy_d = (state_d != ST_IDLE);
        done_d = 1'b0;
        pix_rd = 1'b0;

        case (state_d)
            ST_LINE: begin
                if (word_cnt_d == 16'd0) begin
                    ctrl_d = (line_cnt_d == 16'd0) ? FS_CODE : LS_CODE;
                end else if (word_cnt_d == line_words_d - 16'd1) begin
                    ctrl_d = last_line_d ? FE_CODE : LE_CODE;
                end else begin
                    ctrl_d = IMG_CODE;
                end
`ifdef PYTHON_ENC_TESTPAT_EN
                for (int unsigned c = 0; c < CHANNEL_NUM; c++) begin
                    data_d[c*SENSOR_DAT_WIDTH +: SENSOR_DAT_WIDTH] =
                        SENSOR_DAT_WIDTH'(32'(word_cnt_d) * 32'(CHANNEL_NUM) + 32'(c));
                end
`else
                pix_rd = 1'b1;
                data_d = iv_pix_data;
`endif
                done_d = (word_cnt_d == line_words_d - 16'd1) && last_line_d &&
                         (blank_words_d == 16'd0);
            end
            ST_BLANK: begin
                ctrl_d = BL_CODE;
                done_d = (word_cnt_d == blank_words_d - 16'd1) && last_line_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            line_cnt_q    <= '0;
            word_cnt_q    <= '0;
            line_num_q    <= '0;
            line_words_q  <= '0;
            blank_words_q <= '0;
            ctrl_q        <= TR_CODE;
            data_q        <= {CHANNEL_NUM{TR_CODE}};
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            line_cnt_q    <= line_cnt_d;
            word_cnt_q    <= word_cnt_d;
            line_num_q    <= line_num_d;
            line_words_q  <= line_words_d;
            blank_words_q <= blank_words_d;
            ctrl_q        <= ctrl_d;
            data_q        <= data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign o_pix_rd     = pix_rd & ~reset;
    assign ov_ctrl      = ctrl_q;
    assign ov_data      = data_q;
    assign o_busy       = busy_q;
    assign o_frame_done = done_q;

endmodule

// File: doc/python_timing_encoder.md
PYTHON_TIMING_ENCODER -- requirements
Module: python_timing_encoder

Interface
REQ-001 SHALL have parameter CHANNEL_NUM, default 4, number of pixel data channels.
REQ-002 SHALL have parameter SENSOR_DAT_WIDTH, default 10, bits per channel word.
REQ-003 SHALL have parameters TR_CODE 10'h3A6, FS_CODE 10'h2AA, FE_CODE 10'h3AA, LS_CODE 10'h0AA, LE_CODE 10'h12A, BL_CODE 10'h015, IMG_CODE 10'h035, the sync-channel codes.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_start  input  1  frame start request, sampled per cycle.
REQ-007 SHALL have port iv_line_num  input  16  lines per frame.
REQ-008 SHALL have port iv_line_words  input  16  words per line per channel.
REQ-009 SHALL have port iv_blank_words  input  16  horizontal blank words after each line.
REQ-010 SHALL have port iv_pix_data  input  CHANNEL_NUM*SENSOR_DAT_WIDTH  pixel words, first-word-fall-through.
REQ-011 SHALL have port o_pix_rd  output  1  pixel consume strobe, combinational.
REQ-012 SHALL have port ov_data  output  CHANNEL_NUM*SENSOR_DAT_WIDTH  data-channel words, registered.
REQ-013 SHALL have port ov_ctrl  output  SENSOR_DAT_WIDTH  sync-channel word, registered.
REQ-014 SHALL have port o_busy  output  1  high from frame start until frame end.
REQ-015 SHALL have port o_frame_done  output  1  one-cycle pulse on the last blank word of the frame.

Function
REQ-016 SHALL implement states IDLE, LINE, BLANK.
REQ-017 In IDLE, every output word SHALL be TR_CODE on ov_ctrl and on every data channel.
REQ-018 i_start high in IDLE at cycle N SHALL latch the three size inputs, with these clamps: line_words<2 to 2; line_num=0 to 1.
REQ-019 The first LINE word SHALL appear on the outputs at cycle N+1.
REQ-020 i_start SHALL be ignored outside IDLE; size inputs SHALL be ignored except at the latch.
REQ-021 LINE SHALL last line_words cycles. ov_ctrl word 0 = FS_CODE on line 0, else LS_CODE. Last word = FE_CODE on the last line, else LE_CODE. Other words = IMG_CODE.
REQ-022 In LINE, ov_data SHALL be iv_pix_data registered.
REQ-023 o_pix_rd SHALL be high exactly in the cycle before each LINE output word, so one read yields one word: exactly line_words*line_num reads per frame.
REQ-024 BLANK SHALL last blank_words cycles with ov_ctrl=BL_CODE and data channels=TR_CODE. blank_words=0 SHALL skip BLANK, giving back-to-back lines.
REQ-025 After the last line's BLANK, or its last LINE word if blank_words=0, the next output SHALL be IDLE/TR. o_frame_done SHALL pulse aligned with the final non-TR output word.
REQ-026 i_start high in the same cycle as the frame-done pulse SHALL be ignored. The earliest new frame SHALL start from an i_start sampled in IDLE.
REQ-027 Line and word counters SHALL be 16-bit and SHALL NOT wrap. Counts reach at most latched value minus 1.
REQ-028 o_busy SHALL be high from N+1 through the cycle of o_frame_done, inclusive.

Reset
REQ-029 reset SHALL force IDLE, clear all counters and latched sizes, and set ov_ctrl and each data channel to TR_CODE, o_pix_rd=0, o_busy=0, o_frame_done=0.
REQ-030 reset asserted mid-frame SHALL abort the frame with no o_frame_done. TR output SHALL appear on the cycle after reset is sampled.

Configuration
REQ-031 Macro PYTHON_ENC_TESTPAT_EN defined: iv_pix_data SHALL be ignored, o_pix_rd SHALL be held 0, and channel c word k of each line SHALL be (k*CHANNEL_NUM+c) mod 2^SENSOR_DAT_WIDTH, with k restarting at 0 on each line.
REQ-032 Macro PYTHON_ENC_TESTPAT_EN undefined: data SHALL come from iv_pix_data as in REQ-022/023.

Verification
REQ-033 Frame: lines=2, words=4, blank=3, i_start at cycle 10 -> ov_ctrl sequence from cycle 11 = FS,IMG,IMG,LE,BL,BL,BL,LS,IMG,IMG,FE,BL,BL,BL, then TR; o_frame_done high in cycle 24; 8 o_pix_rd pulses.
REQ-034 Clamp: lines=0, words=1, blank=0 -> ov_ctrl = FS then FE, then TR; o_frame_done coincides with FE.
REQ-035 Busy guard: second i_start 3 cycles after the first, and another coinciding with o_frame_done -> single frame emitted; i_start one cycle after done starts a new frame.
REQ-036 Reset mid-frame on line 1 word 2 -> TR on all channels the next cycle, o_busy=0, no o_frame_done, next i_start gives a normal FS-led frame.
REQ-037 Data path: iv_pix_data = incrementing count advanced on o_pix_rd, 4 channels -> ov_data matches the values popped, in order, with no drops or duplicates.
REQ-038 With PYTHON_ENC_TESTPAT_EN, words=3, CHANNEL_NUM=4 -> channel 2 words = 2,6,10 on every line; o_pix_rd stays 0.
